// File: rtl/risky_pkg.sv
// Shared definitions for the risky single-cycle RISC core.
// Contents: size constants, opcode enum, register indices R0..R7,
// NOP_INST/HALT_INST instruction constants and the LOADC_INST encoder.
// Instruction layout: op=inst[15:11], rd=inst[10:8], ra=inst[5:3], rb=inst[2:0],
// shift amount inst[4:0], LOADC immediate inst[7:0], branch offset inst[5:0].
package risky_pkg;

  localparam int INSTRUCTION_SIZE = 16;
  localparam int ADDRESS_SIZE     = 10;
  localparam int DATA_SIZE        = 32;
  localparam int REG_COUNT        = 8;
  localparam int REG_SEL_SIZE     = 3;

  typedef enum logic [4:0] {
    OP_NOP   = 5'b00000,
    OP_ADD   = 5'b00001,
    OP_SUB   = 5'b00010,
    OP_AND   = 5'b00011,
    OP_OR    = 5'b00100,
    OP_XOR   = 5'b00101,
    OP_NAND  = 5'b00110,
    OP_NOR   = 5'b00111,
    OP_XNOR  = 5'b01000,
    OP_SHL   = 5'b01001,
    OP_SHR   = 5'b01010,
    OP_SAR   = 5'b01011,
    OP_LOADC = 5'b01100,
    OP_LOAD  = 5'b01101,
    OP_STORE = 5'b01110,
    OP_JMP   = 5'b01111,
    OP_JMPR  = 5'b10000,
    OP_BEQZ  = 5'b10001,
    OP_BNEZ  = 5'b10010,
    OP_MUL   = 5'b10011,
    OP_HALT  = 5'b11111
  } opcode_t;

  typedef enum logic [REG_SEL_SIZE-1:0] {
    R0 = 3'd0, R1 = 3'd1, R2 = 3'd2, R3 = 3'd3,
    R4 = 3'd4, R5 = 3'd5, R6 = 3'd6, R7 = 3'd7
  } reg_idx_t;

  localparam logic [INSTRUCTION_SIZE-1:0] NOP_INST  = 16'h0000;
  localparam logic [INSTRUCTION_SIZE-1:0] HALT_INST = 16'hFFFF;

  // Encode "LOADC rd, imm": opcode, destination, 8-bit immediate.
  function automatic logic [INSTRUCTION_SIZE-1:0] LOADC_INST(
    input logic [REG_SEL_SIZE-1:0] rd,
    input logic [7:0]              imm
  );
    return {5'(OP_LOADC), rd, imm};
  endfunction

endpackage

// File: rtl/risky_alu.sv
// Combinational ALU of the risky core.
// Ports:
//   op     in  opcode_t  decoded opcode
//   a      in  32        first operand (ra for logic/arith, rd for shifts)
//   b      in  32        second operand (rb)
//   shamt  in  5         shift amount
//   result out 32        operation result, 0 for non-ALU opcodes
// Optional feature: CORE_MUL_EN adds MUL (low 32 bits of a*b).
module risky_alu
  import risky_pkg::*;
(
  input  opcode_t              op,
  input  logic [DATA_SIZE-1:0] a,
  input  logic [DATA_SIZE-1:0] b,
  input  logic [4:0]           shamt,
  output logic [DATA_SIZE-1:0] result
);

  // Operation select; arithmetic wraps modulo 2^32, no flags.
  always_comb begin
    result = 32'd0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_SHL:  result = a << shamt;
      OP_SHR:  result = a >> shamt;
      OP_SAR:  result = $unsigned($signed(a) >>> shamt);
`ifdef CORE_MUL_EN
      OP_MUL:  result = a * b;
`else
`endif
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/risky_core.sv
// Single-cycle 8x32-bit register RISC core, one instruction per clock.
// Ports:
//   clock        in   1   rising-edge clock
//   reset        in   1   asynchronous, active-low
//   instruction  in   16  word fetched at pc, used in the same cycle
//   pc           out  10  program counter (registered)
//   read         out  1   data-memory read strobe
//   write        out  1   data-memory write strobe
//   address      out  10  data-memory address
//   data_out     out  32  store data
//   data_in      in   32  load data, valid while read is high
// Optional feature: define CORE_MUL_EN to execute opcode 10011 as MUL;
// otherwise it decodes as NOP.
module risky_core
  import risky_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic [INSTRUCTION_SIZE-1:0] instruction,
  output logic [ADDRESS_SIZE-1:0]     pc,
  output logic                        read,
  output logic                        write,
  output logic [ADDRESS_SIZE-1:0]     address,
  output logic [DATA_SIZE-1:0]        data_out,
  input  logic [DATA_SIZE-1:0]        data_in
);

  logic [DATA_SIZE-1:0]    regs [REG_COUNT];
  logic                    halted;

  opcode_t                 op;
  logic [REG_SEL_SIZE-1:0] rd_idx;
  logic [REG_SEL_SIZE-1:0] ra_idx;
  logic [REG_SEL_SIZE-1:0] rb_idx;
  logic [DATA_SIZE-1:0]    rd_val;
  logic [DATA_SIZE-1:0]    ra_val;
  logic [DATA_SIZE-1:0]    rb_val;
  logic [DATA_SIZE-1:0]    alu_a;
  logic [DATA_SIZE-1:0]    alu_result;
  logic [ADDRESS_SIZE-1:0] pc_inc;
  logic [ADDRESS_SIZE-1:0] pc_rel;
  logic [ADDRESS_SIZE-1:0] next_pc;
  logic                    wr_en;
  logic [DATA_SIZE-1:0]    wr_data;
  logic                    set_halt;
  logic                    mem_rd;
  logic                    mem_wr;
  logic [ADDRESS_SIZE-1:0] mem_addr;
  logic [DATA_SIZE-1:0]    mem_dout;

  assign op     = opcode_t'(instruction[15:11]);
  assign rd_idx = instruction[10:8];
  assign ra_idx = instruction[5:3];
  assign rb_idx = instruction[2:0];
  assign rd_val = regs[rd_idx];
  assign ra_val = regs[ra_idx];
  assign rb_val = regs[rb_idx];

  // pc arithmetic wraps naturally at the 10-bit width.
  assign pc_inc = pc + 10'd1;
  assign pc_rel = pc + {{4{instruction[5]}}, instruction[5:0]};

  // Shifts operate on rd in place; everything else reads ra.
  always_comb begin
    alu_a = ra_val;
    case (op)
      OP_SHL, OP_SHR, OP_SAR: alu_a = rd_val;
      default:                alu_a = ra_val;
    endcase
  end

  risky_alu u_alu (
    .op     (op),
    .a      (alu_a),
    .b      (rb_val),
    .shamt  (instruction[4:0]),
    .result (alu_result)
  );

  // Decode: next pc, register write-back, halt request and memory access.
  always_comb begin
    next_pc  = pc_inc;
    wr_en    = 1'b0;
    wr_data  = 32'd0;
    set_halt = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = 10'd0;
    mem_dout = 32'd0;
    if (!halted) begin
      case (op)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR,
        OP_SHL, OP_SHR, OP_SAR: begin
          wr_en   = 1'b1;
          wr_data = alu_result;
        end
`ifdef CORE_MUL_EN
        OP_MUL: begin
          wr_en   = 1'b1;
          wr_data = alu_result;
        end
`else
`endif
        OP_LOADC: begin
          wr_en   = 1'b1;
          wr_data = {24'd0, instruction[7:0]};
        end
        OP_LOAD: begin
          mem_rd   = 1'b1;
          mem_addr = rb_val[ADDRESS_SIZE-1:0];
          wr_en    = 1'b1;
          wr_data  = data_in;
        end
        OP_STORE: begin
          mem_wr   = 1'b1;
          mem_addr = rd_val[ADDRESS_SIZE-1:0];
          mem_dout = rb_val;
        end
        OP_JMP:  next_pc = rb_val[ADDRESS_SIZE-1:0];
        OP_JMPR: next_pc = pc_rel;
        OP_BEQZ: begin
          if (rd_val == 32'd0) begin
            next_pc = pc_rel;
          end else begin
            next_pc = pc_inc;
          end
        end
        OP_BNEZ: begin
          if (rd_val != 32'd0) begin
            next_pc = pc_rel;
          end else begin
            next_pc = pc_inc;
          end
        end
        // HALT leaves pc pointing at itself.
        OP_HALT: begin
          set_halt = 1'b1;
          next_pc  = pc;
        end
        default: next_pc = pc_inc;
      endcase
    end else begin
      next_pc = pc;
    end
  end

  // Memory interface is forced quiet while reset is asserted.
  always_comb begin
    if (reset) begin
      read     = mem_rd;
      write    = mem_wr;
      address  = mem_addr;
      data_out = mem_dout;
    end else begin
      read     = 1'b0;
      write    = 1'b0;
      address  = 10'd0;
      data_out = 32'd0;
    end
  end

  // Architectural state: pc, halt flag and register file.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc     <= 10'd0;
      halted <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= 32'd0;
      end
    end else begin
      pc     <= next_pc;
      halted <= halted | set_halt;
      if (wr_en) begin
        regs[rd_idx] <= wr_data;
      end else begin
        regs[rd_idx] <= regs[rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_risky_core.sv
// Self-checking bench for risky_core. Register contents are observed by
// applying a STORE (rd=R0, rb=Rn) between edges and reading data_out.
`timescale 1ns/1ps
module tb_risky_core;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instruction = 16'h0000;
  logic [9:0]  pc;
  logic        read;
  logic        write;
  logic [9:0]  address;
  logic [31:0] data_out;
  logic [31:0] data_in = 32'd0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] inst;
    logic [31:0] din;
    logic        exp_read;
    logic        exp_write;
    logic [9:0]  exp_addr;
    logic [31:0] exp_dout;
    logic [9:0]  exp_pc;
    logic        probe;
    logic [2:0]  preg;
    logic [31:0] pval;
  } vec_t;

  vec_t        vecs[$];
  logic [9:0]  pc_q[$];

  risky_core dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .pc          (pc),
    .read        (read),
    .write       (write),
    .address     (address),
    .data_out    (data_out),
    .data_in     (data_in)
  );

  always #50 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] rr(input logic [4:0] op, input logic [2:0] d,
                                     input logic [2:0] a, input logic [2:0] b);
    return {op, d, 2'b00, a, b};
  endfunction

  function automatic logic [15:0] sh(input logic [4:0] op, input logic [2:0] d,
                                     input logic [4:0] s);
    return {op, d, 3'b000, s};
  endfunction

  function automatic logic [15:0] br(input logic [4:0] op, input logic [2:0] d,
                                     input logic [5:0] off);
    return {op, d, 2'b00, off};
  endfunction

  function automatic logic [15:0] lc(input logic [2:0] d, input logic [7:0] imm);
    return {5'b01100, d, imm};
  endfunction

  function automatic vec_t mk(input logic [15:0] inst, input logic [31:0] din,
                              input logic r, input logic w, input logic [9:0] a,
                              input logic [31:0] dout, input logic [9:0] npc,
                              input logic p, input logic [2:0] preg,
                              input logic [31:0] pval);
    vec_t v;
    v.inst = inst; v.din = din; v.exp_read = r; v.exp_write = w;
    v.exp_addr = a; v.exp_dout = dout; v.exp_pc = npc;
    v.probe = p; v.preg = preg; v.pval = pval;
    return v;
  endfunction

  // Register-writing or control instruction with no memory activity.
  function automatic vec_t mkq(input logic [15:0] inst, input logic [9:0] npc,
                               input logic p, input logic [2:0] preg,
                               input logic [31:0] pval);
    return mk(inst, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, npc, p, preg, pval);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic probe(input logic [2:0] r, input logic [31:0] exp, input string tag);
    instruction = {5'b01110, 3'd0, 2'b00, 3'd0, r};
    data_in     = 32'd0;
    #1;
    check({tag, " probe_write"}, {31'd0, write}, 32'd1);
    check({tag, " probe_reg"}, data_out, exp);
  endtask

  // Drive one instruction, check strobes before the edge, pc after it.
  task automatic run_one(input vec_t v, input string tag);
    logic [9:0] exp_pc;
    instruction = v.inst;
    data_in     = v.din;
    pc_q.push_back(v.exp_pc);
    #1;
    check({tag, " read"},     {31'd0, read},  {31'd0, v.exp_read});
    check({tag, " write"},    {31'd0, write}, {31'd0, v.exp_write});
    check({tag, " address"},  {22'd0, address}, {22'd0, v.exp_addr});
    check({tag, " data_out"}, data_out, v.exp_dout);
    @(posedge clock);
    #1;
    if (pc_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s pc: got empty scoreboard expected entry", tag);
    end else begin
      exp_pc = pc_q.pop_front();
      check({tag, " pc"}, {22'd0, pc}, {22'd0, exp_pc});
    end
    if (v.probe) begin
      probe(v.preg, v.pval, tag);
    end
  endtask

  initial begin
    logic [7:0]  lvals [8];
    logic [31:0] mul_exp;

`ifdef CORE_MUL_EN
    mul_exp = 32'h0000008F;
`else
    mul_exp = 32'hFFFFFFF9;
`endif
    lvals = '{8'h0D, 8'h0E, 8'h0A, 8'h0D, 8'h0B, 8'h0A, 8'h0B, 8'h0E};

    // Main program table.
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mkq(lc(3'(i), lvals[i]), 10'(i + 1), 1'b1, 3'(i), {24'd0, lvals[i]}));
    end
    vecs.push_back(mkq(rr(5'b00001, 3'd2, 3'd0, 3'd1), 10'd9,  1'b1, 3'd2, 32'h0000001B));
    vecs.push_back(mkq(br(5'b10010, 3'd0, 6'h3E),      10'd7,  1'b1, 3'd0, 32'h0000000D));
    vecs.push_back(mkq(rr(5'b00010, 3'd3, 3'd0, 3'd1), 10'd8,  1'b1, 3'd3, 32'hFFFFFFFF));
    vecs.push_back(mk(rr(5'b01110, 3'd5, 3'd0, 3'd7), 32'd0, 1'b0, 1'b1, 10'h00A,
                      32'h0000000E, 10'd9, 1'b1, 3'd5, 32'h0000000A));
    vecs.push_back(mk(rr(5'b01101, 3'd4, 3'd0, 3'd5), 32'h12345678, 1'b1, 1'b0, 10'h00A,
                      32'd0, 10'd10, 1'b1, 3'd4, 32'h12345678));
    vecs.push_back(mkq(br(5'b10001, 3'd0, 6'h05),      10'd11, 1'b0, 3'd0, 32'd0));
    vecs.push_back(mkq(rr(5'b01111, 3'd0, 3'd0, 3'd6), 10'h00B, 1'b0, 3'd0, 32'd0));
    vecs.push_back(mkq(sh(5'b01001, 3'd1, 5'd28),      10'd12, 1'b1, 3'd1, 32'hE0000000));
    vecs.push_back(mkq(sh(5'b01011, 3'd1, 5'd4),       10'd13, 1'b1, 3'd1, 32'hFE000000));
    vecs.push_back(mkq(sh(5'b01010, 3'd1, 5'd25),      10'd14, 1'b1, 3'd1, 32'h0000007F));
    vecs.push_back(mkq(rr(5'b00011, 3'd2, 3'd0, 3'd6), 10'd15, 1'b1, 3'd2, 32'h00000009));
    vecs.push_back(mkq(rr(5'b00100, 3'd2, 3'd0, 3'd6), 10'd16, 1'b1, 3'd2, 32'h0000000F));
    vecs.push_back(mkq(rr(5'b00101, 3'd2, 3'd0, 3'd6), 10'd17, 1'b1, 3'd2, 32'h00000006));
    vecs.push_back(mkq(rr(5'b00110, 3'd2, 3'd0, 3'd6), 10'd18, 1'b1, 3'd2, 32'hFFFFFFF6));
    vecs.push_back(mkq(rr(5'b00111, 3'd2, 3'd0, 3'd6), 10'd19, 1'b1, 3'd2, 32'hFFFFFFF0));
    vecs.push_back(mkq(rr(5'b01000, 3'd2, 3'd0, 3'd6), 10'd20, 1'b1, 3'd2, 32'hFFFFFFF9));
    vecs.push_back(mkq(rr(5'b00001, 3'd1, 3'd1, 3'd1), 10'd21, 1'b1, 3'd1, 32'h000000FE));
    vecs.push_back(mkq(rr(5'b00010, 3'd4, 3'd4, 3'd3), 10'd22, 1'b1, 3'd4, 32'h12345679));
    vecs.push_back(mkq(lc(3'd3, 8'h00),                10'd23, 1'b1, 3'd3, 32'd0));
    vecs.push_back(mkq(br(5'b10001, 3'd3, 6'h05),      10'd28, 1'b0, 3'd0, 32'd0));
    vecs.push_back(mkq(br(5'b10010, 3'd3, 6'h05),      10'd29, 1'b0, 3'd0, 32'd0));
    vecs.push_back(mkq({5'b10100, 3'd0, 8'hFF},        10'd30, 1'b1, 3'd0, 32'h0000000D));
    vecs.push_back(mkq(rr(5'b10011, 3'd2, 3'd0, 3'd6), 10'd31, 1'b1, 3'd2, mul_exp));
    vecs.push_back(mkq(lc(3'd2, 8'hFF),                10'd32, 1'b0, 3'd0, 32'd0));
    vecs.push_back(mkq(sh(5'b01001, 3'd2, 5'd2),       10'd33, 1'b1, 3'd2, 32'h000003FC));
    vecs.push_back(mkq(lc(3'd3, 8'h03),                10'd34, 1'b0, 3'd0, 32'd0));
    vecs.push_back(mkq(rr(5'b00100, 3'd2, 3'd2, 3'd3), 10'd35, 1'b1, 3'd2, 32'h000003FF));
    vecs.push_back(mkq(rr(5'b01111, 3'd0, 3'd0, 3'd2), 10'h3FF, 1'b0, 3'd0, 32'd0));
    vecs.push_back(mkq(16'h0000,                       10'h000, 1'b0, 3'd0, 32'd0));
    vecs.push_back(mkq(br(5'b10000, 3'd0, 6'h3F),      10'h3FF, 1'b0, 3'd0, 32'd0));
    vecs.push_back(mkq(16'h0000,                       10'h000, 1'b0, 3'd0, 32'd0));
    vecs.push_back(mkq(br(5'b10000, 3'd0, 6'h1F),      10'd31, 1'b0, 3'd0, 32'd0));
    vecs.push_back(mk(rr(5'b01110, 3'd1, 3'd0, 3'd4), 32'd0, 1'b0, 1'b1, 10'h0FE,
                      32'h12345679, 10'd32, 1'b0, 3'd0, 32'd0));
    vecs.push_back(mk(rr(5'b01101, 3'd0, 3'd0, 3'd4), 32'hCAFEF00D, 1'b1, 1'b0, 10'h279,
                      32'd0, 10'd33, 1'b1, 3'd0, 32'hCAFEF00D));
    for (int i = 0; i < 10; i++) begin
      vecs.push_back(mkq(16'h0000, 10'(34 + i), 1'b0, 3'd0, 32'd0));
    end
    vecs.push_back(mkq(16'hFFFF, 10'd43, 1'b0, 3'd0, 32'd0));

    // Reset state, with a STORE on the bus to show strobes are held low.
    instruction = rr(5'b01110, 3'd0, 3'd0, 3'd0);
    #1;
    check("reset pc",       {22'd0, pc}, 32'd0);
    check("reset write",    {31'd0, write}, 32'd0);
    check("reset read",     {31'd0, read}, 32'd0);
    check("reset address",  {22'd0, address}, 32'd0);
    check("reset data_out", data_out, 32'd0);
    #19;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      probe(3'(i), 32'd0, $sformatf("init R%0d", i));
    end

    for (int i = 0; i < vecs.size(); i++) begin
      run_one(vecs[i], $sformatf("vec%0d", i));
    end

    // Halted: pc frozen, memory interface silent even for LOAD/STORE.
    for (int i = 0; i < 12; i++) begin
      case (i % 3)
        0:       run_one(mk(rr(5'b01110, 3'd1, 3'd0, 3'd4), 32'd0, 1'b0, 1'b0, 10'd0,
                            32'd0, 10'd43, 1'b0, 3'd0, 32'd0), $sformatf("halt%0d", i));
        1:       run_one(mk(rr(5'b01101, 3'd0, 3'd0, 3'd4), 32'h55AA55AA, 1'b0, 1'b0, 10'd0,
                            32'd0, 10'd43, 1'b0, 3'd0, 32'd0), $sformatf("halt%0d", i));
        default: run_one(mkq(rr(5'b01111, 3'd0, 3'd0, 3'd6), 10'd43, 1'b0, 3'd0, 32'd0),
                         $sformatf("halt%0d", i));
      endcase
    end

    // Asynchronous reset mid-cycle, aborting a pending LOADC R7.
    #10;
    instruction = lc(3'd7, 8'h55);
    reset = 1'b0;
    #1;
    check("async reset pc", {22'd0, pc}, 32'd0);
    @(posedge clock);
    #1;
    check("reset held pc", {22'd0, pc}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      probe(3'(i), 32'd0, $sformatf("post-reset R%0d", i));
    end
    run_one(mkq(16'h0000, 10'd1, 1'b0, 3'd0, 32'd0), "post-reset nop");
    run_one(mkq(lc(3'd7, 8'h5A), 10'd2, 1'b1, 3'd7, 32'h0000005A), "post-reset loadc");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
